// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and constants for the bit-serial adder
// Holds the controller state enum (IDLE, RUN, DONE) and the default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - single-bit full adder cell
// Ports:
//   a, b, c_in  : operand bits and carry-in
//   sum, c_out  : sum bit and carry-out
module fa_cell (
    output logic c_out,
    output logic sum,
    input  logic a,
    input  logic b,
    input  logic c_in
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial add/subtract unit, LSB first, one full adder
// Optional feature macro: SERIAL_ADDER_OVF_EN (signed overflow flag; tied to 0 when undefined).
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   start           : request a new operation (accepted in IDLE or DONE)
//   a, b            : WIDTH-bit operands
//   c_in            : carry-in, add mode only
//   sub             : 0 = a+b+c_in, 1 = a-b
//   busy            : high while the operation is being computed
//   done            : one-cycle pulse, result valid
//   sum, c_out      : result and carry out of the MSB (sub: 1 = no borrow)
//   overflow        : signed overflow of the last completed result
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_q;
    logic               c_out_q;
    logic               fa_sum, fa_cout;
    logic               load;
    logic               last_bit;

    assign last_bit = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // done still pulses when a back-to-back start is taken here
                done = 1'b1;
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    fa_cell u_fa (
        .c_out (fa_cout),
        .sum   (fa_sum),
        .a     (a_q[0]),
        .b     (b_q[0]),
        .c_in  (carry_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else if (load) begin
            // Subtraction is a + ~b + 1, so the mode is folded into b_q and the seed carry.
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : c_in;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else if (state_q == RUN) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            carry_q <= fa_cout;
            acc_q   <= {fa_sum, acc_q[WIDTH-1:1]};
            cnt_q   <= cnt_q + CNT_W'(1);
            // Visible result only moves on the final bit, so sum/c_out stay stable while running.
            if (last_bit) begin
                sum_q   <= {fa_sum, acc_q[WIDTH-1:1]};
                c_out_q <= fa_cout;
            end
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // On the final bit carry_q is the carry into the MSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (last_bit) begin
            ovf_q <= carry_q ^ fa_cout;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (WIDTH=8)
module tb_serial_adder;

    localparam int WIDTH = 8;

`ifdef SERIAL_ADDER_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] last_sum;

    typedef struct {
        logic [7:0] av;
        logic [7:0] bv;
        logic       cin;
        logic       sb;
        logic [7:0] esum;
        logic       ecout;
        logic       eovf;
    } vec_t;

    vec_t vecs [7];

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .sub      (sub),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; launches one operation and returns at the negedge where done is seen.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic cin, input logic sb,
                          input bit intrude, input logic [7:0] hold_sum);
        int lat;
        bit seen;
        start = 1'b1;
        a     = av;
        b     = bv;
        c_in  = cin;
        sub   = sb;
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        c_in  = 1'($urandom);
        sub   = 1'($urandom);
        lat   = 1;
        seen  = 1'b0;
        while (!seen && lat < 20) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (intrude && lat == 3) begin
                    start = 1'b1;
                    a     = 8'h55;
                    b     = 8'h11;
                    sub   = 1'b1;
                end else begin
                    start = 1'b0;
                end
                if (lat == 4) begin
                    chk("busy_run", busy, 1);
                    chk("sum_hold_run", sum, hold_sum);
                end
                @(negedge clk);
                lat++;
            end
        end
        start = 1'b0;
        chk("latency", lat, 9);
    endtask

    initial begin
        int done_seen;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
        vecs[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[6] = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0};

        rst_n = 1'b0;
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        c_in  = 1'b1;
        sub   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", c_out, 0);
        chk("rst_ovf", overflow, 0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        last_sum = 8'h00;

        foreach (vecs[i]) begin
            run_op(vecs[i].av, vecs[i].bv, vecs[i].cin, vecs[i].sb, 1'b0, last_sum);
            chk($sformatf("v%0d_sum", i), sum, vecs[i].esum);
            chk($sformatf("v%0d_cout", i), c_out, vecs[i].ecout);
            chk($sformatf("v%0d_ovf", i), overflow, vecs[i].eovf & OVF_ON);
            chk($sformatf("v%0d_busy_done", i), busy, 0);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), done, 0);
            chk($sformatf("v%0d_sum_hold", i), sum, vecs[i].esum);
            last_sum = vecs[i].esum;
        end

        // Start during RUN with different operands must be ignored.
        run_op(8'h10, 8'h20, 1'b0, 1'b0, 1'b1, last_sum);
        chk("intrude_sum", sum, 8'h30);
        chk("intrude_cout", c_out, 0);
        @(negedge clk);
        chk("intrude_done_pulse", done, 0);
        last_sum = 8'h30;

        // Back-to-back: second start taken in the DONE cycle.
        run_op(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, last_sum);
        chk("b2b_first_sum", sum, 8'h03);
        run_op(8'h10, 8'h22, 1'b0, 1'b0, 1'b0, 8'h03);
        chk("b2b_second_sum", sum, 8'h32);
        @(negedge clk);
        chk("b2b_done_pulse", done, 0);

        // Reset at the 4th RUN cycle aborts the operation.
        start = 1'b1;
        a     = 8'h11;
        b     = 8'h22;
        c_in  = 1'b0;
        sub   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_sum", sum, 0);
        chk("abort_done", done, 0);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);
        run_op(8'h03, 8'h04, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("after_abort_sum", sum, 8'h07);
        chk("after_abort_cout", c_out, 0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: requests a new operation.
REQ-005 SHALL have port a, input, WIDTH bits: operand A, unsigned or two's complement.
REQ-006 SHALL have port b, input, WIDTH bits: operand B.
REQ-007 SHALL have port c_in, input, 1 bit: carry-in, used in add mode only.
REQ-008 SHALL have port sub, input, 1 bit: 0 selects A+B+c_in; 1 selects A-B.
REQ-009 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse marking the result as valid.
REQ-011 SHALL have port sum, output, WIDTH bits: result.
REQ-012 SHALL have port c_out, output, 1 bit: carry out of the MSB (in sub mode, 1 = no borrow).
REQ-013 SHALL have port overflow, output, 1 bit: signed overflow flag (see Configuration).

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-015 In IDLE or DONE, start=1 SHALL latch a, b, c_in and sub into internal registers, clear the bit counter, clear the result register, and move to RUN.
REQ-016 In sub mode the latched B SHALL be ~b and the initial carry SHALL be 1; in add mode the initial carry SHALL be c_in.
REQ-017 In RUN, each cycle SHALL add one bit per operand, LSB first, through a single full-adder cell, shift the sum bit into the result register, and register the carry.
REQ-018 RUN SHALL last exactly WIDTH cycles, then move to DONE.
REQ-019 In DONE, done=1 for exactly one cycle; without start the FSM SHALL then move to IDLE.
REQ-020 Latency: start sampled at edge N SHALL give done=1 in the cycle after edge N+WIDTH.
REQ-021 busy SHALL be 1 only in RUN.
REQ-022 start asserted during RUN SHALL be ignored, with no effect on the operands or on the state.
REQ-023 start asserted in DONE SHALL be accepted (back-to-back operation), and done SHALL still pulse in that cycle.
REQ-024 sum, c_out and overflow SHALL hold the last completed result until the next done.
REQ-025 sum and c_out SHALL not change visibly during RUN; shifting uses an internal register that is copied at the RUN-to-DONE transition.
REQ-026 Inputs a, b, c_in and sub SHALL be don't-care except in the cycle where start is accepted.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force state IDLE, busy=0, done=0, sum=0, c_out=0, overflow=0, and clear the counter and internal registers.
REQ-028 Reset during RUN SHALL abort the operation with no done pulse; the first start after reset SHALL behave normally.
REQ-029 Reset SHALL take priority over start.

Configuration
REQ-030 Macro SERIAL_ADDER_OVF_EN defined: overflow SHALL equal the carry into the MSB XOR the carry out of the MSB, captured at the final RUN cycle.
REQ-031 Macro SERIAL_ADDER_OVF_EN undefined: overflow SHALL be tied to 0, and no overflow logic SHALL be synthesised.

Structure
REQ-032 Shared package serial_adder_pkg SHALL hold the state enum typedef (IDLE, RUN, DONE) and the default-width constant.
REQ-033 The single-bit full adder SHALL be a sub-module named fa_cell (ports c_out, sum, a, b, c_in), instantiated exactly once.
REQ-034 The counter width SHALL be $clog2(WIDTH+1).

Verification (WIDTH=8)
REQ-035 Add: a=0x0F, b=0x01, c_in=0, sub=0 -> done 9 cycles after start, sum=0x10, c_out=0.
REQ-036 Add wrap: a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1, overflow=0; with c_in=1 -> sum=0x01, c_out=1.
REQ-037 Subtract: a=0x05, b=0x07, sub=1 -> sum=0xFE, c_out=0; a=0x80, b=0x01, sub=1 -> sum=0x7F, overflow=1 (macro on) or 0 (macro off).
REQ-038 Signed add: a=0x7F, b=0x01 -> sum=0x80, overflow=1 with SERIAL_ADDER_OVF_EN, 0 without.
REQ-039 Start during RUN with different operands -> ignored; result matches the first operation; two starts back-to-back in DONE -> two done pulses 9 cycles apart.
REQ-040 rst_n=0 at the 4th RUN cycle -> next cycle busy=0, sum=0, no done; the next start with a=0x03, b=0x04 -> sum=0x07.
